// File: rtl/ssd_bcd_scanner.sv
// ---------------------------------------------------------------------------
// ssd_bcd_scanner
//
// Display-side stage between the processor's 13-bit SSD value and a 4-digit
// common-anode seven-segment display. A sequential shift-add-3
// (double-dabble) engine turns the binary value into four BCD digits. A
// free-running refresh counter then multiplexes those digits onto the
// anodes, blanking leading zeros.
//
// Parameters
//   REFRESH_BITS : refresh counter width. The top two bits select the
//                  digit, so each digit is lit for 2^(REFRESH_BITS-2) cycles.
//
// Ports
//   clk      in   1   display clock, rising edge
//   rst      in   1   asynchronous, active-low reset
//   num      in  13   unsigned value to display (0..8191); sampled in IDLE
//   Anode    out  4   active-low digit enables, Anode[0] = ones digit
//   LED_out  out  7   active-low segments, LED_out[6:0] = a..g
//   busy     out  1   high while a conversion is in progress
// ---------------------------------------------------------------------------
module ssd_bcd_scanner #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  output logic [3:0]  Anode,
  output logic [6:0]  LED_out,
  output logic        busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  // Conversion engine state
  state_e                  state_q,    state_d;
  logic [12:0]             last_num_q, last_num_d;
  logic [28:0]             shift_q,    shift_d;
  logic [3:0]              cnt_q,      cnt_d;
  logic [15:0]             disp_q,     disp_d;

  // Scanner state
  logic [REFRESH_BITS-1:0] refresh_q,  refresh_d;
  logic [3:0]              anode_q,    anode_d;
  logic [6:0]              led_q,      led_d;

  // Scanner combinational helpers
  logic [1:0]              sel_s;
  logic [3:0]              digit_s;
  logic                    blank_s;

  // Double-dabble helpers: the register after the add-3 step and after the shift
  logic [28:0]             adj_s;
  logic [28:0]             shifted_s;

  // Add 3 to a BCD nibble that is 5 or more, so that the next left shift
  // carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Active-low segment pattern {a,b,c,d,e,f,g} for one decimal digit.
  // Codes 10..15 cannot occur and are shown dark.
  function automatic logic [6:0] seg_encode(input logic [3:0] dig);
    logic [6:0] seg;
    case (dig)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Add-3 on each BCD nibble, then shift the whole register left by one.
  always_comb begin
    adj_s     = {add3(shift_q[28:25]), add3(shift_q[24:21]),
                 add3(shift_q[20:17]), add3(shift_q[16:13]),
                 shift_q[12:0]};
    shifted_s = adj_s << 1;
  end

  // Conversion FSM: next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    last_num_d = last_num_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    case (state_q)
      ST_IDLE: begin
        // num is quasi-static and is only compared here, so a change seen
        // during CONV is picked up on the following IDLE cycle.
        if (num != last_num_q) begin
          shift_d    = {16'b0, num};
          last_num_d = num;
          cnt_d      = 4'd0;
          state_d    = ST_CONV;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_CONV: begin
        shift_d = shifted_s;
        cnt_d   = cnt_q + 4'd1;
        // The 13th iteration has shifted in the last binary bit; the upper
        // 16 bits now hold thousands/hundreds/tens/ones.
        if (cnt_q == 4'd12) begin
          disp_d  = shifted_s[28:13];
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CONV;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Conversion FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_num_q <= 13'd0;
      shift_q    <= 29'd0;
      cnt_q      <= 4'd0;
      disp_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      last_num_q <= last_num_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
    end
  end

  // Digit select, digit extraction and leading-zero blanking.
  always_comb begin
    sel_s = refresh_q[REFRESH_BITS-1 -: 2];
    case (sel_s)
      2'd0: begin
        digit_s = disp_q[3:0];
        blank_s = 1'b0;  // ones digit is always lit
      end
      2'd1: begin
        digit_s = disp_q[7:4];
        blank_s = (disp_q[15:4] == 12'd0);
      end
      2'd2: begin
        digit_s = disp_q[11:8];
        blank_s = (disp_q[15:8] == 8'd0);
      end
      2'd3: begin
        digit_s = disp_q[15:12];
        blank_s = (disp_q[15:12] == 4'd0);
      end
      default: begin
        digit_s = 4'd0;
        blank_s = 1'b1;
      end
    endcase
  end

  // Scanner next-state: refresh advance and pin patterns for this sel.
  always_comb begin
    refresh_d = refresh_q + REFRESH_BITS'(1);
    anode_d   = ~(4'b0001 << sel_s);
    if (blank_s) begin
      led_d = 7'b1111111;  // anode still asserts, the digit is just dark
    end else begin
      led_d = seg_encode(digit_s);
    end
  end

  // Refresh counter and registered display pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q <= '0;
      anode_q   <= 4'b1111;
      led_q     <= 7'b1111111;
    end else begin
      refresh_q <= refresh_d;
      anode_q   <= anode_d;
      led_q     <= led_d;
    end
  end

  assign Anode   = anode_q;
  assign LED_out = led_q;
  assign busy    = (state_q == ST_CONV);

endmodule
